// File: rtl/lfsr_rand_arbiter.sv
// Shared Fibonacci LFSR bit source packed into OUT_BITS-wide words, each granted round-robin.
// Optional LFSR_RESEED_EN adds a reseed/seed_in port pair for runtime reseeding.
module lfsr_rand_arbiter #(
    parameter int unsigned LFSR_W = 5,
    parameter logic [LFSR_W-1:0] TAPS = 5'b10010,
    parameter logic [LFSR_W-1:0] SEED = 5'b00001,
    parameter int unsigned OUT_BITS = 3,
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                clk,
    input  logic                rst,
`ifdef LFSR_RESEED_EN
    input  logic                reseed,
    input  logic [LFSR_W-1:0]   seed_in,
`endif
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [OUT_BITS-1:0] rnd_data,
    output logic                word_ready
);

    localparam int unsigned CNT_W = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [LFSR_W-1:0]   sr_q, sr_d;
    logic                out_bit, feedback;
    logic [OUT_BITS-1:0] bit_buf_q, bit_buf_d;
    logic [OUT_BITS:0]   shifted;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                complete;
    logic [OUT_BITS-1:0] hold_q, hold_d;
    logic [OUT_BITS-1:0] rnd_q, rnd_d;
    logic [0:0]          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    win, win_next;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  active;
    logic                found, grant;
    int unsigned         idx;

    assign out_bit  = sr_q[LFSR_W-1];
    assign feedback = ^(sr_q & TAPS);
    // First collected bit drifts up to the MSB of the completed word.
    assign shifted  = {bit_buf_q, out_bit};
    assign complete = (cnt_q == CNT_W'(OUT_BITS - 1));
    // A requester whose grant is currently high is ignored to avoid double grants.
    assign active   = req & ~gnt_q;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr_q) + k) % NUM_REQ;
            if (!found && active[PTR_W'(idx)]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
        win_next = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
    end

    assign grant = (state_q == FULL) && found;

    always_comb begin
        sr_d      = {sr_q[LFSR_W-2:0], feedback};
        bit_buf_d = shifted[OUT_BITS-1:0];
        cnt_d     = complete ? '0 : cnt_q + CNT_W'(1);
        hold_d    = hold_q;
        state_d   = state_q;
        gnt_d     = '0;
        rnd_d     = rnd_q;
        ptr_d     = ptr_q;

        if (grant) begin
            gnt_d = NUM_REQ'(1) << win;
            rnd_d = hold_q;
            ptr_d = win_next;
        end

        if (complete) begin
            hold_d = shifted[OUT_BITS-1:0];
        end

        case (state_q)
            EMPTY:   if (complete) state_d = FULL;
            FULL:    if (grant && !complete) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase

`ifdef LFSR_RESEED_EN
        // Reseed wins over grant and completion; any pending word is discarded.
        if (reseed) begin
            sr_d      = (seed_in != '0) ? seed_in : SEED;
            bit_buf_d = '0;
            cnt_d     = '0;
            hold_d    = hold_q;
            state_d   = EMPTY;
            gnt_d     = '0;
            rnd_d     = rnd_q;
            ptr_d     = ptr_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q      <= SEED;
            bit_buf_q <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            state_q   <= EMPTY;
            ptr_q     <= '0;
            gnt_q     <= '0;
            rnd_q     <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_buf_q <= bit_buf_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            rnd_q     <= rnd_d;
        end
    end

    assign gnt        = gnt_q;
    assign rnd_data   = rnd_q;
    assign word_ready = (state_q == FULL);

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Directed bench for lfsr_rand_arbiter with default parameters; expected words come from
// the known 31-bit LFSR stream 0000101011101100011111001101001.
module tb_lfsr_rand_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [2:0] rnd_data;
    logic       word_ready;
`ifdef LFSR_RESEED_EN
    logic       reseed;
    logic [4:0] seed_in;
`endif

    int passed;
    int total;

    lfsr_rand_arbiter dut (
        .clk        (clk),
        .rst        (rst),
`ifdef LFSR_RESEED_EN
        .reseed     (reseed),
        .seed_in    (seed_in),
`endif
        .req        (req),
        .gnt        (gnt),
        .rnd_data   (rnd_data),
        .word_ready (word_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance n rising edges and sample 1 time unit later.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] req_val);
        @(negedge clk);
        rst = 1'b1;
        req = req_val;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        req    = 4'b0000;
`ifdef LFSR_RESEED_EN
        reseed  = 1'b0;
        seed_in = 5'd0;
`endif
        #1;
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_word_ready", 32'(word_ready), 32'h0);
        check("reset_rnd_data", 32'(rnd_data), 32'h0);

        // Idle requesters: words complete every 3 edges and overwrite each other.
        do_reset(4'b0000);
        step(2);
        check("idle_e2_word_ready", 32'(word_ready), 32'h0);
        step(1);
        check("idle_e3_word_ready", 32'(word_ready), 32'h1);
        check("idle_e3_gnt", 32'(gnt), 32'h0);
        step(1);
        check("idle_e4_gnt", 32'(gnt), 32'h0);
        check("idle_e4_word_ready", 32'(word_ready), 32'h1);
        step(5);
        check("idle_e9_word_ready", 32'(word_ready), 32'h1);
        check("idle_e9_gnt", 32'(gnt), 32'h0);
        req = 4'b0100;
        step(1);
        check("late_e10_gnt", 32'(gnt), 32'h4);
        check("late_e10_rnd", 32'(rnd_data), 32'h5);
        check("late_e10_word_ready", 32'(word_ready), 32'h0);
        step(1);
        check("late_e11_gnt", 32'(gnt), 32'h0);
        check("late_e11_rnd_hold", 32'(rnd_data), 32'h5);
        req = 4'b0000;

        // All requesters active from reset: round-robin over words 0,2,5,6,6.
        do_reset(4'b1111);
        step(4);
        check("rr_e4_gnt", 32'(gnt), 32'h1);
        check("rr_e4_rnd", 32'(rnd_data), 32'h0);
        step(1);
        check("rr_e5_gnt", 32'(gnt), 32'h0);
        step(2);
        check("rr_e7_gnt", 32'(gnt), 32'h2);
        check("rr_e7_rnd", 32'(rnd_data), 32'h2);
        step(3);
        check("rr_e10_gnt", 32'(gnt), 32'h4);
        check("rr_e10_rnd", 32'(rnd_data), 32'h5);
        step(3);
        check("rr_e13_gnt", 32'(gnt), 32'h8);
        check("rr_e13_rnd", 32'(rnd_data), 32'h6);
        step(3);
        check("rr_e16_gnt", 32'(gnt), 32'h1);
        check("rr_e16_rnd", 32'(rnd_data), 32'h6);

        // Single requester held high: one grant per completed word, never back-to-back.
        do_reset(4'b0010);
        for (int e = 1; e <= 12; e++) begin
            step(1);
            check($sformatf("solo_e%0d_gnt", e), 32'(gnt),
                  (e == 4 || e == 7 || e == 10) ? 32'h2 : 32'h0);
        end

        // Asynchronous reset while a grant pulse is in flight.
        do_reset(4'b0010);
        step(7);
        check("arst_pre_gnt", 32'(gnt), 32'h2);
        rst = 1'b1;
        req = 4'b1111;
        #1;
        check("arst_gnt", 32'(gnt), 32'h0);
        check("arst_word_ready", 32'(word_ready), 32'h0);
        check("arst_rnd", 32'(rnd_data), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(4);
        check("arst_e4_gnt", 32'(gnt), 32'h1);
        check("arst_e4_rnd", 32'(rnd_data), 32'h0);
        step(3);
        check("arst_e7_gnt", 32'(gnt), 32'h2);
        check("arst_e7_rnd", 32'(rnd_data), 32'h2);

`ifdef LFSR_RESEED_EN
        // Reseed with seed_in=0 discards the pending word and restarts from SEED.
        do_reset(4'b0000);
        step(3);
        check("rs_pre_word_ready", 32'(word_ready), 32'h1);
        @(negedge clk);
        reseed  = 1'b1;
        seed_in = 5'd0;
        req     = 4'b1111;
        step(1);
        check("rs_word_ready", 32'(word_ready), 32'h0);
        check("rs_gnt", 32'(gnt), 32'h0);
        reseed = 1'b0;
        step(3);
        check("rs_e3_gnt", 32'(gnt), 32'h0);
        check("rs_e3_word_ready", 32'(word_ready), 32'h1);
        step(1);
        check("rs_e4_gnt", 32'(gnt), 32'h1);
        check("rs_e4_rnd", 32'(rnd_data), 32'h0);
        step(3);
        check("rs_e7_rnd", 32'(rnd_data), 32'h2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
